// File: rtl/bi_shift_register_pkg.sv
// Shared constants and the clocked-operation decode for the snake-grid shift register.
package bi_shift_register_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_MASK = 2'd0,
    OP_SHR  = 2'd1,
    OP_SHL  = 2'd2
  } op_e;

  // Right shift wins when both directions are requested on the same edge.
  function automatic op_e decode_op(input logic shift_right, input logic shift_left);
    if (shift_right)     return OP_SHR;
    else if (shift_left) return OP_SHL;
    else                 return OP_MASK;
  endfunction

endpackage

// File: rtl/bi_shift_register_cell.sv
// One bit of the grid row: async clear/preset flop with a shift/masked-load next-state mux.
module bi_shift_cell
  import bi_shift_register_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic pre,
  input  op_e  op,
  input  logic msb_nbr,
  input  logic lsb_nbr,
  input  logic ups_en,
  input  logic ups_val,
  input  logic downs_en,
  input  logic downs_val,
  output logic q
);

  logic d;

  always_comb begin
    d = q;
    case (op)
      OP_SHR:  d = msb_nbr;
      OP_SHL:  d = lsb_nbr;
      default: begin
        if (ups_en)        d = ups_val;
        else if (downs_en) d = downs_val;
      end
    endcase
  end

  // Clear dominates preset, so reset beats a concurrent parallel load.
  always_ff @(posedge clk or posedge clr or posedge pre) begin
    if (clr)      q <= 1'b0;
    else if (pre) q <= 1'b1;
    else          q <= d;
  end

endmodule

// File: rtl/bi_shift_register.sv
// Bidirectional shift register with async clear, async parallel load and per-bit masked loads.
module bi_shift_register
  import bi_shift_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_right,
  input  logic             shift_left,
  input  logic             set,
  input  logic [WIDTH-1:0] load_in,
  input  logic [WIDTH-1:0] load_ups,
  input  logic [WIDTH-1:0] load_downs,
  input  logic [WIDTH-1:0] load_ups_values,
  input  logic [WIDTH-1:0] load_downs_values,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pre;
  logic [WIDTH+1:0] q_pad;
  op_e              op;

  // Preset is qualified by reset so releasing reset during set re-presets the ones.
  assign clr   = {WIDTH{~reset}} | ({WIDTH{set}} & ~load_in);
  assign pre   = {WIDTH{reset & set}} & load_in;
  assign q_pad = {1'b0, q, 1'b0};
  assign op    = decode_op(shift_right, shift_left);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bi_shift_cell u_cell (
      .clk       (clk),
      .clr       (clr[i]),
      .pre       (pre[i]),
      .op        (op),
      .msb_nbr   (q_pad[i+2]),
      .lsb_nbr   (q_pad[i]),
      .ups_en    (load_ups[i]),
      .ups_val   (load_ups_values[i]),
      .downs_en  (load_downs[i]),
      .downs_val (load_downs_values[i]),
      .q         (q[i])
    );
  end

  assign parallel_out = q;

endmodule

// File: tb/tb_bi_shift_register.sv
// Self-checking bench for bi_shift_register: directed scenarios plus a randomized model comparison.
module tb_bi_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         shift_right;
  logic         shift_left;
  logic         set;
  logic [W-1:0] load_in;
  logic [W-1:0] load_ups;
  logic [W-1:0] load_downs;
  logic [W-1:0] load_ups_values;
  logic [W-1:0] load_downs_values;
  logic [W-1:0] parallel_out;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] m;

  bi_shift_register #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .shift_right       (shift_right),
    .shift_left        (shift_left),
    .set               (set),
    .load_in           (load_in),
    .load_ups          (load_ups),
    .load_downs        (load_downs),
    .load_ups_values   (load_ups_values),
    .load_downs_values (load_downs_values),
    .parallel_out      (parallel_out)
  );

  always #5 clk = ~clk;

  // Behavioural next value after one clocked edge.
  function automatic logic [W-1:0] model_step(
    input logic [W-1:0] q, input logic sr, input logic sl,
    input logic [W-1:0] ups, input logic [W-1:0] upsv,
    input logic [W-1:0] dns, input logic [W-1:0] dnsv);
    if (sr) return q / 2;
    if (sl) return (q * 2) % 256;
    return (q & ~ups & ~dns) | (upsv & ups) | (dnsv & dns & ~ups);
  endfunction

  task automatic tick();
    m = model_step(m, shift_right, shift_left, load_ups, load_ups_values,
                   load_downs, load_downs_values);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    shift_right = 0; shift_left = 0; set = 0; load_in = '0;
    load_ups = '0; load_downs = '0; load_ups_values = '0; load_downs_values = '0;
  endtask

  task automatic pulse_set(input logic [W-1:0] v);
    load_in = v; set = 1'b1; #1;
    set = 1'b0; #1;
    m = v;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    pulse_set(8'hFF);
    total++;
    if (parallel_out !== 8'hFF) begin bad++; $display("FAIL preload got=%h exp=%h", parallel_out, 8'hFF); end
    reset = 1'b0; #1;
    m = '0;
    total++;
    if (parallel_out !== 8'h00) begin bad++; $display("FAIL async_reset got=%h exp=%h", parallel_out, 8'h00); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (parallel_out !== 8'h00) begin bad++; $display("FAIL reset_hold[%0d] got=%h exp=%h", i, parallel_out, 8'h00); end
    end
  endtask

  task automatic test_shift_right();
    pulse_set(8'hA5);
    total++;
    if (parallel_out !== 8'hA5) begin bad++; $display("FAIL set_load got=%h exp=%h", parallel_out, 8'hA5); end
    shift_right = 1'b1;
    tick();
    total++;
    if (parallel_out !== 8'h52) begin bad++; $display("FAIL shr_first got=%h exp=%h", parallel_out, 8'h52); end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if (parallel_out !== m) begin bad++; $display("FAIL shr[%0d] got=%h exp=%h", i, parallel_out, m); end
    end
    total++;
    if (parallel_out !== 8'h00) begin bad++; $display("FAIL shr_empty got=%h exp=%h", parallel_out, 8'h00); end
    shift_right = 1'b0;
  endtask

  task automatic test_shift_left();
    pulse_set(8'h81);
    shift_left = 1'b1;
    tick();
    total++;
    if (parallel_out !== 8'h02) begin bad++; $display("FAIL shl_first got=%h exp=%h", parallel_out, 8'h02); end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if (parallel_out !== m) begin bad++; $display("FAIL shl[%0d] got=%h exp=%h", i, parallel_out, m); end
    end
    total++;
    if (parallel_out !== 8'h00) begin bad++; $display("FAIL shl_empty got=%h exp=%h", parallel_out, 8'h00); end
    pulse_set(8'h81);
    shift_right = 1'b1;
    tick();
    total++;
    if (parallel_out !== 8'h40) begin bad++; $display("FAIL both_dir got=%h exp=%h", parallel_out, 8'h40); end
    shift_right = 1'b0; shift_left = 1'b0;
  endtask

  task automatic test_masked_loads();
    logic [W-1:0] walk_exp;
    pulse_set(8'h00);
    load_ups_values = 8'hFF;
    walk_exp = '0;
    for (int k = 0; k < 8; k++) begin
      load_ups = 8'h80 >> k;
      walk_exp = walk_exp | (8'h80 >> k);
      tick();
      total++;
      if (parallel_out !== walk_exp) begin bad++; $display("FAIL ups_walk[%0d] got=%h exp=%h", k, parallel_out, walk_exp); end
    end
    load_ups = '0; load_ups_values = '0;
    pulse_set(8'h00);
    load_downs_values = 8'hFF;
    walk_exp = '0;
    for (int k = 0; k < 8; k++) begin
      load_downs = 8'h80 >> k;
      walk_exp = walk_exp | (8'h80 >> k);
      tick();
      total++;
      if (parallel_out !== walk_exp) begin bad++; $display("FAIL downs_walk[%0d] got=%h exp=%h", k, parallel_out, walk_exp); end
    end
    load_downs = '0; load_downs_values = '0;
  endtask

  task automatic test_conflict();
    pulse_set(8'h00);
    load_ups = 8'h0F; load_downs = 8'h0F;
    load_ups_values = 8'h05; load_downs_values = 8'h0A;
    tick();
    total++;
    if (parallel_out !== 8'h05) begin bad++; $display("FAIL ups_over_downs got=%h exp=%h", parallel_out, 8'h05); end
    pulse_set(8'h01);
    shift_left = 1'b1;
    tick();
    total++;
    if (parallel_out !== 8'h02) begin bad++; $display("FAIL shift_over_mask got=%h exp=%h", parallel_out, 8'h02); end
    idle_inputs();
  endtask

  task automatic test_override();
    pulse_set(8'hF0);
    shift_right = 1'b1;
    tick();
    total++;
    if (parallel_out !== 8'h78) begin bad++; $display("FAIL ovr_shift got=%h exp=%h", parallel_out, 8'h78); end
    #3;
    load_in = 8'h3C; set = 1'b1; #1;
    total++;
    if (parallel_out !== 8'h3C) begin bad++; $display("FAIL ovr_set got=%h exp=%h", parallel_out, 8'h3C); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (parallel_out !== 8'h3C) begin bad++; $display("FAIL ovr_hold[%0d] got=%h exp=%h", i, parallel_out, 8'h3C); end
    end
    load_in = 8'hC3; #1;
    total++;
    if (parallel_out !== 8'hC3) begin bad++; $display("FAIL ovr_track got=%h exp=%h", parallel_out, 8'hC3); end
    reset = 1'b0; #1;
    total++;
    if (parallel_out !== 8'h00) begin bad++; $display("FAIL ovr_reset got=%h exp=%h", parallel_out, 8'h00); end
    set = 1'b0; shift_right = 1'b0; #1;
    reset = 1'b1; #1;
    m = '0;
    total++;
    if (parallel_out !== 8'h00) begin bad++; $display("FAIL ovr_release got=%h exp=%h", parallel_out, 8'h00); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      shift_right       = ($urandom_range(0, 5) == 0);
      shift_left        = ($urandom_range(0, 5) == 0);
      load_ups          = W'($urandom) & W'($urandom);
      load_downs        = W'($urandom) & W'($urandom);
      load_ups_values   = W'($urandom);
      load_downs_values = W'($urandom);
      if ($urandom_range(0, 19) == 0) pulse_set(W'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0; #1; reset = 1'b1; #1;
        m = '0;
      end
      tick();
      total++;
      if (parallel_out !== m) begin bad++; $display("FAIL random[%0d] got=%h exp=%h", n, parallel_out, m); end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    m = '0;
    idle_inputs();
    test_reset();
    test_shift_right();
    test_shift_left();
    test_masked_loads();
    test_conflict();
    test_override();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bi_shift_register.md
Name: bi_shift_register

Overview:
- Parameterised bidirectional shift register with asynchronous clear, asynchronous parallel load, and per-bit masked loads from two independent sources ("ups" and "downs").
- Holds one row/column of the snake-game grid state.
- The game logic shifts the row left or right, loads a full pattern, or sets or clears individual cells.

Parameters:
- WIDTH, 8, register width in bits; all vector ports are WIDTH wide.

Ports:
- clk  input  1  rising-edge clock for shift and masked-load operations.
- reset  input  1  asynchronous, active-low clear. 0 forces parallel_out to all zeros.
- shift_right  input  1  on a clk rising edge, shift toward the LSB.
- shift_left  input  1  on a clk rising edge, shift toward the MSB.
- set  input  1  asynchronous, active-high, level-sensitive parallel load of load_in.
- load_in  input  WIDTH  parallel data captured while set=1.
- load_ups  input  WIDTH  per-bit enable mask for load_ups_values.
- load_downs  input  WIDTH  per-bit enable mask for load_downs_values.
- load_ups_values  input  WIDTH  data for bits enabled by load_ups.
- load_downs_values  input  WIDTH  data for bits enabled by load_downs.
- parallel_out  output  WIDTH  current register contents, driven directly from flops.

Behaviour:
- Asynchronous priority (highest first):
  1. reset=0: q = 0 immediately, independent of clk.
  2. set=1 (with reset=1): q = load_in immediately. q tracks load_in while set stays high.
- Synchronous operations apply on a clk rising edge only when reset=1 and set=0. Priority, highest first:
  1. shift_right=1: q <= {1'b0, q[WIDTH-1:1]}. The MSB fills with 0 and the LSB is discarded.
  2. shift_left=1 (and shift_right=0): q <= {q[WIDTH-2:0], 1'b0}. The LSB fills with 0 and the MSB is discarded.
  3. No shift requested: each bit i updates independently.
     - load_ups[i]=1: q[i] <= load_ups_values[i].
     - else load_downs[i]=1: q[i] <= load_downs_values[i].
     - else q[i] holds.
- When a shift is active, load_ups and load_downs are ignored for that edge.
- Both shift_right and shift_left high on the same edge: shift right wins.
- A bit enabled in both load_ups and load_downs takes the ups value.
- Latency:
  - Asynchronous paths (reset, set) act combinationally to the flop outputs.
  - Synchronous operations are visible on parallel_out one edge later (zero-cycle register output after the edge).
- No wrap-around or rotation: after WIDTH consecutive shifts in the same direction, q = 0.
- Reset or set asserted mid-operation overrides any clock activity immediately.
- After reset deasserts, the register holds 0 until the next set or clocked operation.
- Power-up value before the first reset is undefined. A bench must reset first.
- The flop model must be synthesizable with asynchronous clear plus asynchronous load.
  - Implement each bit as an async-clear / async-preset flop: preset when set & load_in[i], clear when !reset or (set & !load_in[i]).
  - Or use the target library's async-load flop.
- No handshakes and no internal state machine.

Decomposition:
- No shared package is required. WIDTH is the only constant.
- One natural sub-module, bi_shift_cell: a single-bit flop with async clear/load and a next-state mux (left neighbour, right neighbour, ups value, downs value, hold).
- The top level instantiates WIDTH cells in a generate loop and ties the end neighbours to 0.

Test Plan:
1. reset=0 with no clock, after prior contents 8'hFF -> parallel_out=8'h00 immediately. Release reset -> remains 8'h00 across 3 clocks with all controls 0.
2. reset=1, load_in=8'hA5, pulse set with no clock -> out=8'hA5. Then shift_right=1 for 1 edge -> 8'h52. 7 more edges -> 8'h00.
3. set load 8'h81, shift_left=1: 1 edge -> 8'h02. 8 edges total -> 8'h00. Both shift inputs high on 8'h81 -> 8'h40 (right wins).
4. Clear to 8'h00, load_ups_values=8'hFF, load_ups walking 8'h80>>k, one per edge -> out 8'h80, 8'hC0, …, 8'hFF after 8 edges. Repeat with load_downs/load_downs_values=8'hFF -> identical sequence.
5. Conflict case, q=8'h00, load_ups=load_downs=8'h0F, ups_values=8'h05, downs_values=8'h0A -> after one edge out=8'h05. With shift_left=1 on the same edge and q=8'h01 -> 8'h02 (masks ignored).
6. Override case, clocking with shift_right=1 on 8'hF0, raise set with load_in=8'h3C mid-cycle -> out=8'h3C immediately and held through edges while set=1. Assert reset=0 while set=1 -> out=8'h00.
